// File: rtl/raster_pkg.sv
// ---------------------------------------------------------------------------
// raster_pkg
// Shared types and constants for the triangle scheduler and its clear
// sweeper.
//   vert_t         one vertex, [0] = z, [1] = y, [2] = x, 9 bits each
//   sched_state_t  scheduler FSM states
//   FB_ADDR_W      frame buffer address width
//   FB_WIDTH/HEIGHT default frame buffer dimensions
// ---------------------------------------------------------------------------
package raster_pkg;

  localparam int FB_ADDR_W = 17;
  localparam int FB_WIDTH  = 360;
  localparam int FB_HEIGHT = 360;

  typedef logic [2:0][8:0] vert_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_FETCH,
    ST_ISSUE,
    ST_BUSY,
    ST_DRAIN,
    ST_READY
  } sched_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/raster_sched_clear_sweeper.sv
// ---------------------------------------------------------------------------
// clear_sweeper
// Walks the write-side frame buffer address range once per start pulse,
// asserting the write enable for exactly NUM_PIX consecutive cycles with
// addresses 0 .. NUM_PIX-1.
// Ports:
//   clk_i     system clock
//   rst_i     asynchronous active-high reset
//   start_i   begin a sweep at address 0 (restarts a running sweep)
//   we_o      clear write enable
//   addr_o    clear address
//   done_o    high during the cycle that writes the final address
// ---------------------------------------------------------------------------
module clear_sweeper
  import raster_pkg::*;
#(
  parameter int NUM_PIX = FB_WIDTH * FB_HEIGHT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 we_o,
  output logic [FB_ADDR_W-1:0] addr_o,
  output logic                 done_o
);

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(NUM_PIX - 1);

  logic                 we_q, we_d;
  logic [FB_ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    we_d   = we_q;
    addr_d = addr_q;
    if (start_i) begin
      we_d   = 1'b1;
      addr_d = '0;
    end else if (we_q) begin
      if (addr_q == LAST_ADDR) begin
        we_d   = 1'b0;
        addr_d = '0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
    end
  end

  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign done_o = we_q && (addr_q == LAST_ADDR);

endmodule

// File: rtl/raster_sched.sv
// ---------------------------------------------------------------------------
// raster_sched
// Triangle scheduler between the transform stage and the rasterizer. Takes
// one triangle at a time over valid/ready, holds its vertices stable while
// the rasterizer works on it, and after the last triangle of an object waits
// for the video frame tick before issuing the buffer-swap pulse.
//
// Build option: RASTER_CLEAR_EN adds a CLEAR state that sweeps the write-side
// z/color buffer after reset and after every swap. Without it the clear
// outputs are tied to 0.
//
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   tri_valid_in/ready_out    upstream triangle handshake
//   tri_last_in               triangle is the last of the object
//   tri_v1/v2/v3_in           incoming vertices
//   rast_idle_in              rasterizer sits in its receive state
//   vert1/2/3_out             vertices held for the rasterizer
//   valid_tri_out             one-cycle triangle start pulse
//   obj_done_out              one-cycle pulse when the last triangle drained
//   new_frame_out             one-cycle buffer-swap pulse
//   frame_tick_in             video frame-start pulse
//   clear_we_out/addr_out     buffer clear write port
//   late_frames_out           saturating count of ticks that came too early
//
// state | meaning
// ------+--------------------------------------------------------------
// CLEAR | sweeping the write buffer (RASTER_CLEAR_EN only)
// FETCH | ready for the next triangle
// ISSUE | triangle held, waiting for the rasterizer to be idle
// BUSY  | start pulse sent, waiting for the rasterizer to leave idle
// DRAIN | rasterizer working, waiting for it to return to idle
// READY | object finished, waiting for the frame tick to swap
// ---------------------------------------------------------------------------
module raster_sched
  import raster_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 tri_valid_in,
  output logic                 tri_ready_out,
  input  logic                 tri_last_in,
  input  vert_t                tri_v1_in,
  input  vert_t                tri_v2_in,
  input  vert_t                tri_v3_in,
  input  logic                 rast_idle_in,
  output vert_t                vert1_out,
  output vert_t                vert2_out,
  output vert_t                vert3_out,
  output logic                 valid_tri_out,
  output logic                 obj_done_out,
  output logic                 new_frame_out,
  input  logic                 frame_tick_in,
  output logic                 clear_we_out,
  output logic [FB_ADDR_W-1:0] clear_addr_out,
  output logic [7:0]           late_frames_out
);

  localparam longint FB_SIZE = longint'(WIDTH) * longint'(HEIGHT);

  if (FB_SIZE > (longint'(1) << FB_ADDR_W)) begin : g_size_check
    $error("raster_sched: WIDTH*HEIGHT does not fit the clear address width");
  end

  sched_state_t state_q;
  vert_t        vert1_q, vert2_q, vert3_q;
  logic         last_q;
  logic         tri_ready_q;
  logic         valid_tri_q;
  logic         obj_done_q;
  logic         new_frame_q;
  logic [7:0]   late_q, late_d;

  // A tick only swaps when it lands in READY; anywhere else it is late,
  // including the cycle in which DRAIN hands over to READY.
  assign late_d = (frame_tick_in && (state_q != ST_READY)) ? sat_inc8(late_q) : late_q;

`ifdef RASTER_CLEAR_EN
  logic clr_armed_q;
  logic clr_start;
  logic clr_done;

  // The sweep is kicked once on the first CLEAR cycle; clr_armed_q keeps it
  // from being restarted while the sweep runs.
  assign clr_start = (state_q == ST_CLEAR) && !clr_armed_q;

  clear_sweeper #(
    .NUM_PIX(WIDTH * HEIGHT)
  ) u_clear_sweeper (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .start_i(clr_start),
    .we_o   (clear_we_out),
    .addr_o (clear_addr_out),
    .done_o (clr_done)
  );
`else
  assign clear_we_out   = 1'b0;
  assign clear_addr_out = '0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
`ifdef RASTER_CLEAR_EN
      state_q     <= ST_CLEAR;
      clr_armed_q <= 1'b0;
`else
      state_q     <= ST_FETCH;
`endif
      vert1_q     <= '0;
      vert2_q     <= '0;
      vert3_q     <= '0;
      last_q      <= 1'b0;
      tri_ready_q <= 1'b0;
      valid_tri_q <= 1'b0;
      obj_done_q  <= 1'b0;
      new_frame_q <= 1'b0;
      late_q      <= '0;
    end else begin
      valid_tri_q <= 1'b0;
      obj_done_q  <= 1'b0;
      new_frame_q <= 1'b0;
      late_q      <= late_d;

      case (state_q)
`ifdef RASTER_CLEAR_EN
        ST_CLEAR: begin
          clr_armed_q <= 1'b1;
          if (clr_done) begin
            state_q     <= ST_FETCH;
            tri_ready_q <= 1'b1;
          end
        end
`endif
        ST_FETCH: begin
          // Vertices are only ever loaded here; the rasterizer builds its
          // bounding box combinationally from them while it works.
          if (tri_valid_in && tri_ready_q) begin
            vert1_q     <= tri_v1_in;
            vert2_q     <= tri_v2_in;
            vert3_q     <= tri_v3_in;
            last_q      <= tri_last_in;
            tri_ready_q <= 1'b0;
            state_q     <= ST_ISSUE;
          end else begin
            tri_ready_q <= 1'b1;
          end
        end

        ST_ISSUE: begin
          if (rast_idle_in) begin
            valid_tri_q <= 1'b1;
            state_q     <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          // Idle dropping is the rasterizer's acknowledgement of the start.
          if (!rast_idle_in) begin
            state_q <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (rast_idle_in) begin
            if (last_q) begin
              obj_done_q <= 1'b1;
              state_q    <= ST_READY;
            end else begin
              tri_ready_q <= 1'b1;
              state_q     <= ST_FETCH;
            end
          end
        end

        ST_READY: begin
          if (frame_tick_in) begin
            new_frame_q <= 1'b1;
`ifdef RASTER_CLEAR_EN
            clr_armed_q <= 1'b0;
            state_q     <= ST_CLEAR;
`else
            tri_ready_q <= 1'b1;
            state_q     <= ST_FETCH;
`endif
          end
        end

        default: begin
          tri_ready_q <= 1'b0;
          state_q     <= ST_FETCH;
        end
      endcase
    end
  end

  assign tri_ready_out   = tri_ready_q;
  assign vert1_out       = vert1_q;
  assign vert2_out       = vert2_q;
  assign vert3_out       = vert3_q;
  assign valid_tri_out   = valid_tri_q;
  assign obj_done_out    = obj_done_q;
  assign new_frame_out   = new_frame_q;
  assign late_frames_out = late_q;

endmodule

// File: tb/tb_raster_sched.sv
module tb_raster_sched;
  import raster_pkg::*;

`ifdef RASTER_CLEAR_EN
  localparam int TB_W = 24;
  localparam int TB_H = 10;
`else
  localparam int TB_W = 360;
  localparam int TB_H = 360;
`endif

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 tri_valid_in;
  logic                 tri_ready_out;
  logic                 tri_last_in;
  vert_t                tri_v1_in, tri_v2_in, tri_v3_in;
  logic                 rast_idle_in;
  vert_t                vert1_out, vert2_out, vert3_out;
  logic                 valid_tri_out;
  logic                 obj_done_out;
  logic                 new_frame_out;
  logic                 frame_tick_in;
  logic                 clear_we_out;
  logic [FB_ADDR_W-1:0] clear_addr_out;
  logic [7:0]           late_frames_out;

  raster_sched #(.WIDTH(TB_W), .HEIGHT(TB_H)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .tri_valid_in   (tri_valid_in),
    .tri_ready_out  (tri_ready_out),
    .tri_last_in    (tri_last_in),
    .tri_v1_in      (tri_v1_in),
    .tri_v2_in      (tri_v2_in),
    .tri_v3_in      (tri_v3_in),
    .rast_idle_in   (rast_idle_in),
    .vert1_out      (vert1_out),
    .vert2_out      (vert2_out),
    .vert3_out      (vert3_out),
    .valid_tri_out  (valid_tri_out),
    .obj_done_out   (obj_done_out),
    .new_frame_out  (new_frame_out),
    .frame_tick_in  (frame_tick_in),
    .clear_we_out   (clear_we_out),
    .clear_addr_out (clear_addr_out),
    .late_frames_out(late_frames_out)
  );

  always #5 clk_in = ~clk_in;

  // reference model state
  int n_total = 0, n_bad = 0;
  int late_exp = 0;
  int n_acc = 0, n_obj = 0, n_swap = 0;
  bit tick_en = 1'b0;

  // observed event counts, sampled mid-cycle
  int mon_pulses = 0, mon_obj = 0, mon_swap = 0, mon_overlap = 0;
  always @(posedge clk_in) begin
    #2;
    if (valid_tri_out === 1'b1) mon_pulses++;
    if (obj_done_out === 1'b1) mon_obj++;
    if (new_frame_out === 1'b1) mon_swap++;
    if (valid_tri_out === 1'b1 && tri_ready_out === 1'b1) mon_overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic nedge();
    @(negedge clk_in);
  endtask

  function automatic vert_t mk(input int z, input int y, input int x);
    return {9'(x), 9'(y), 9'(z)};
  endfunction

  function automatic vert_t rand_vert();
    logic [31:0] r;
    r = $urandom;
    return r[26:0];
  endfunction

  // Drive frame_tick for the coming edge; callers only use this while the
  // scheduler cannot be in READY, so every tick here is a late one.
  task automatic maybe_tick(input bit force_t);
    frame_tick_in = force_t || (tick_en && ($urandom_range(0, 5) == 0));
    if (frame_tick_in && late_exp < 255) late_exp++;
  endtask

  task automatic wait_clear();
`ifdef RASTER_CLEAR_EN
    int n, guard, bad_addr;
    guard = 0;
    while (clear_we_out !== 1'b1 && guard < 10) begin nedge(); guard++; end
    n = 0; bad_addr = 0;
    while (clear_we_out === 1'b1 && n < TB_W * TB_H + 10) begin
      if (clear_addr_out !== FB_ADDR_W'(n)) bad_addr++;
      n++;
      nedge();
    end
    chk("clear_len", n, TB_W * TB_H);
    chk("clear_addr_seq", bad_addr, 0);
    chk("clear_then_ready", 32'(tri_ready_out), 1);
`endif
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tri_valid_in = 1'b0;
    frame_tick_in = 1'b0;
    rast_idle_in = 1'b1;
    #1;
    chk("rst_pulses", 32'({valid_tri_out, obj_done_out, new_frame_out, tri_ready_out, clear_we_out}), 0);
    chk("rst_late", 32'(late_frames_out), 0);
    chk("rst_vert", 32'(vert1_out | vert2_out | vert3_out), 0);
    chk("rst_addr", 32'(clear_addr_out), 0);
    nedge();
    nedge();
    rst_in = 1'b0;
    late_exp = 0;
    wait_clear();
  endtask

  task automatic send_tri(input vert_t a, input vert_t b, input vert_t c, input bit last,
                          input int gate, input int busy, input bit hold,
                          input int tick_a, input int tick_b, input bit drain_tick);
    int g, early, quiet, bad_hold;
    g = 0;
    while (tri_ready_out !== 1'b1 && g < 2000) begin maybe_tick(1'b0); nedge(); g++; end
    chk("accept_ready", 32'(tri_ready_out), 1);
    tri_valid_in = 1'b1;
    tri_v1_in = a; tri_v2_in = b; tri_v3_in = c;
    tri_last_in = last;
    rast_idle_in = (gate == 0);
    maybe_tick(1'b0);
    nedge();
    n_acc++;
    if (!hold) tri_valid_in = 1'b0;
    chk("ready_after_accept", 32'(tri_ready_out), 0);
    chk("vert1_capture", 32'(vert1_out), 32'(a));
    chk("vert2_capture", 32'(vert2_out), 32'(b));
    chk("vert3_capture", 32'(vert3_out), 32'(c));
    early = 0; quiet = 0; bad_hold = 0;
    for (int i = 0; i < gate; i++) begin
      maybe_tick(1'b0);
      nedge();
      if (valid_tri_out !== 1'b0) early++;
    end
    rast_idle_in = 1'b1;
    maybe_tick(1'b0);
    nedge();
    chk("issue_gated", early, 0);
    chk("valid_tri_pulse", 32'(valid_tri_out), 1);
    rast_idle_in = 1'b0;
    for (int i = 0; i < busy; i++) begin
      maybe_tick(i == tick_a || i == tick_b);
      nedge();
      if (valid_tri_out !== 1'b0 || tri_ready_out !== 1'b0 || obj_done_out !== 1'b0) quiet++;
      if (vert1_out !== a || vert2_out !== b || vert3_out !== c) bad_hold++;
    end
    rast_idle_in = 1'b1;
    maybe_tick(drain_tick);
    nedge();
    frame_tick_in = 1'b0;
    chk("vert_hold", bad_hold, 0);
    chk("busy_quiet", quiet, 0);
    chk("obj_done_latency", 32'(obj_done_out), 32'(last));
    if (last) begin
      n_obj++;
      nedge();
      chk("obj_done_width", 32'(obj_done_out), 0);
      chk("ready_low_in_ready", 32'(tri_ready_out), 0);
      chk("late_count", 32'(late_frames_out), late_exp);
    end else begin
      chk("ready_after_drain", 32'(tri_ready_out), 1);
    end
  endtask

  task automatic do_swap(input int wait_c);
    int early;
    early = 0;
    frame_tick_in = 1'b0;
    for (int i = 0; i < wait_c; i++) begin
      nedge();
      if (new_frame_out !== 1'b0) early++;
    end
    chk("no_swap_before_tick", early, 0);
    frame_tick_in = 1'b1;
    nedge();
    frame_tick_in = 1'b0;
    n_swap++;
    chk("new_frame_latency", 32'(new_frame_out), 1);
    chk("late_kept_on_swap", 32'(late_frames_out), late_exp);
    nedge();
    chk("new_frame_width", 32'(new_frame_out), 0);
    wait_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, pulses;
    rst_in = 1'b1;
    tri_valid_in = 1'b0;
    tri_last_in = 1'b0;
    tri_v1_in = '0; tri_v2_in = '0; tri_v3_in = '0;
    rast_idle_in = 1'b1;
    frame_tick_in = 1'b0;
    repeat (2) nedge();
    do_reset();

    // single triangle, long raster, two early ticks, then a swap
    send_tri(mk(1, 10, 20), mk(1, 50, 20), mk(1, 10, 60), 1'b1, 0, 30, 1'b0, 0, 5, 1'b0);
    chk("late_two_ticks", 32'(late_frames_out), 2);
    do_swap(3);

    // back-to-back with valid held high; tick coincides with DRAIN->READY
    send_tri(mk(3, 4, 5), mk(6, 7, 8), mk(9, 10, 11), 1'b0, 0, 4, 1'b1, -1, -1, 1'b0);
    send_tri(mk(12, 13, 14), mk(15, 16, 17), mk(18, 19, 20), 1'b0, 1, 4, 1'b1, -1, -1, 1'b0);
    send_tri(mk(21, 22, 23), mk(24, 25, 26), mk(27, 28, 29), 1'b1, 0, 4, 1'b1, -1, -1, 1'b1);
    tri_valid_in = 1'b0;
    chk("late_drain_edge", 32'(late_frames_out), 3);
    do_swap(0);
    chk("b2b_pulses", mon_pulses, n_acc);
    chk("b2b_overlap", mon_overlap, 0);

    // early tick saturation
    for (int i = 0; i < 300; i++) begin
      frame_tick_in = 1'b1;
      if (late_exp < 255) late_exp++;
      nedge();
      frame_tick_in = 1'b0;
      nedge();
      if (i == 99) chk("late_mid", 32'(late_frames_out), late_exp);
    end
    chk("late_saturated", 32'(late_frames_out), 255);
`ifndef RASTER_CLEAR_EN
    chk("clear_tied_off", 32'({clear_we_out, clear_addr_out}), 0);
`endif

    // reset in the middle of a triangle
    g = 0;
    while (tri_ready_out !== 1'b1 && g < 2000) begin nedge(); g++; end
    tri_valid_in = 1'b1;
    tri_v1_in = mk(7, 7, 7); tri_v2_in = mk(8, 8, 8); tri_v3_in = mk(9, 9, 9);
    tri_last_in = 1'b1;
    nedge();
    tri_valid_in = 1'b0;
    n_acc++;
    nedge();
    chk("abort_valid_seen", 32'(valid_tri_out), 1);
    rast_idle_in = 1'b0;
    repeat (3) nedge();
    do_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      nedge();
      if (obj_done_out !== 1'b0 || new_frame_out !== 1'b0 || valid_tri_out !== 1'b0) pulses++;
    end
    chk("no_pulse_after_abort", pulses, 0);
    chk("late_cleared", 32'(late_frames_out), 0);

    // randomized frames with random early ticks
    for (int f = 0; f < 6; f++) begin
      int ntri;
      ntri = $urandom_range(1, 4);
      tick_en = 1'b1;
      for (int t = 0; t < ntri; t++)
        send_tri(rand_vert(), rand_vert(), rand_vert(), (t == ntri - 1),
                 $urandom_range(0, 3), $urandom_range(1, 12), 1'($urandom_range(0, 1)),
                 -1, -1, 1'($urandom_range(0, 1)));
      tick_en = 1'b0;
      tri_valid_in = 1'b0;
      do_swap($urandom_range(0, 4));
    end

    nedge();
    chk("pulse_count", mon_pulses, n_acc);
    chk("obj_done_count", mon_obj, n_obj);
    chk("swap_count", mon_swap, n_swap);
    chk("ready_valid_overlap", mon_overlap, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/raster_sched.md
# raster_sched

Triangle scheduler sitting between the transform stage and the rasterizer. It accepts triangles over a valid/ready handshake, presents one triangle at a time to the rasterizer and holds the vertices stable until rasterization finishes. After the last triangle of an object it waits for the video frame tick and then issues the buffer-swap pulse. Optionally, it sweeps the write-side z/color buffer clear before each frame.

## Interface

Parameters:
- WIDTH, 360: frame buffer width in pixels
- HEIGHT, 360: frame buffer height in pixels

Ports:
- clk_in  in  1  system clock; the single clock domain
- rst_in  in  1  reset, asynchronous, active-high
- tri_valid_in  in  1  upstream triangle valid
- tri_ready_out  out  1  scheduler can accept a triangle
- tri_last_in  in  1  qualifies the triangle as the last of the object/frame
- tri_v1_in, tri_v2_in, tri_v3_in  in  3x9 each  vertices, index 0 = z, 1 = y, 2 = x
- rast_idle_in  in  1  rasterizer is in its receive state
- vert1_out, vert2_out, vert3_out  out  3x9 each  vertices presented to the rasterizer
- valid_tri_out  out  1  one-cycle triangle start pulse
- obj_done_out  out  1  one-cycle pulse when the last triangle has drained
- new_frame_out  out  1  one-cycle buffer-swap pulse
- frame_tick_in  in  1  one-cycle pulse from video timing at frame start
- clear_we_out  out  1  clear write enable to the write-side buffer
- clear_addr_out  out  17  clear address
- late_frames_out  out  8  saturating count of ticks that arrived before the frame was ready

## Operation

States: CLEAR, FETCH, ISSUE, BUSY, DRAIN, READY.

- **CLEAR** (present only with the macro)
  - clear_we_out = 1 every cycle.
  - clear_addr_out steps 0 to WIDTH*HEIGHT-1.
  - After the final address, go to FETCH.
- **FETCH**
  - tri_ready_out = 1.
  - On tri_valid_in & tri_ready_out: register the three vertices and tri_last_in, then go to ISSUE.
- **ISSUE**
  - When rast_idle_in = 1: valid_tri_out = 1 for one cycle, then go to BUSY.
- **BUSY**
  - Wait for rast_idle_in = 0, which is the rasterizer's acknowledgement. Then go to DRAIN.
- **DRAIN**
  - Wait for rast_idle_in = 1.
  - If the last flag is set: pulse obj_done_out and go to READY. Otherwise go to FETCH.
- **READY**
  - On frame_tick_in: pulse new_frame_out for one cycle.
  - Next state is CLEAR with the macro, FETCH without it.

Vertex hold rule: vert*_out change only on a FETCH capture. They stay constant through ISSUE, BUSY and DRAIN, because the rasterizer derives its bounding box combinationally from them.

Late-frame rule:
- A frame_tick_in in any state other than READY increments late_frames_out, saturating at 255. No swap is issued for that tick.
- A tick in the same cycle as the DRAIN to READY transition counts as late.
- The counter clears only on reset.

Arithmetic:
- clear_addr_out is 17 bits. WIDTH*HEIGHT must be at most 2^17, which is checked by an elaboration-time assertion.
- The address is compared against WIDTH*HEIGHT-1; there is no wrap-around.

## Timing

Reset values:
- Every output is 0.
- The state is CLEAR with the macro, FETCH without it.
- An asserted rst_in aborts any sweep or triangle immediately. No pulse is emitted on release.

Latencies (all outputs registered):
- Capture to valid_tri_out: at least 1 cycle, gated by rast_idle_in.
- Rasterizer idle after the last triangle to obj_done_out: 1 cycle.
- frame_tick_in in READY to new_frame_out: 1 cycle.
- A full clear lasts exactly WIDTH*HEIGHT cycles.

Handshake limits:
- tri_ready_out is 0 outside FETCH, giving at most one triangle in flight.
- valid_tri_out never asserts twice without an intervening BUSY/DRAIN.

## Configuration

RASTER_CLEAR_EN
- **Defined:** the CLEAR state exists. It runs after reset and after every new_frame_out pulse.
- **Undefined:**
  - The CLEAR state is removed.
  - clear_we_out is tied to 0 and clear_addr_out to 0.
  - After reset and after a swap, the state goes straight to FETCH.

## Structure

Shared package raster_pkg holds:
- vert_t (logic [2:0][8:0])
- sched_state_t
- FB_ADDR_W = 17
- default FB_WIDTH and FB_HEIGHT

One sub-module, clear_sweeper, holds the address counter with start/done. It is instantiated only under RASTER_CLEAR_EN.

## Test plan

- Reset release with the macro defined: clear_we_out high for exactly 129600 cycles, addresses 0 to 129599, then tri_ready_out = 1.
- One triangle (1,10,20)/(1,50,20)/(1,10,60) with last = 1; rasterizer model holds idle low for 30 cycles:
  - one valid_tri_out pulse;
  - vertices stable throughout;
  - obj_done_out exactly 1 cycle after idle returns high.
- Three triangles back-to-back with tri_valid_in held high: tri_ready_out accepts each only in FETCH, giving three valid_tri_out pulses with no overlap.
- Two frame_tick_in pulses during BUSY, then one in READY: late_frames_out = 2, and new_frame_out pulses once, 1 cycle after the third tick.
- 300 early ticks: late_frames_out saturates at 255.
- rst_in asserted in the middle of BUSY: outputs 0 immediately, and no obj_done_out or new_frame_out pulse after release.
